// File: rtl/gemm_tile_sequencer.sv
// Walks the m/n/k block-tiled GEMM loop, driving SRAM A/B read addresses and ReadLatency-delayed beat strobes; stall_i freezes issue and inserts bubbles.
// Optional GEMM_SEQ_PERF_CNT_EN adds a saturating 32-bit busy-cycle counter on perf_cycles_o.
module gemm_tile_sequencer #(
  parameter int AddrWidth     = 12,
  parameter int SizeAddrWidth = 8,
  parameter int ReadLatency   = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  input  logic                     stall_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic                     data_valid_o,
  output logic                     first_k_o,
  output logic                     last_k_o,
  output logic [AddrWidth-1:0]     c_addr_o,
  output logic                     busy_o,
  output logic                     done_o
`ifdef GEMM_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]              perf_cycles_o
`endif
);

  localparam logic [SizeAddrWidth-1:0] SizeOne   = SizeAddrWidth'(1);
  localparam logic [AddrWidth-1:0]     AddrOne   = AddrWidth'(1);
  localparam logic [2:0]               DrainLast = 3'(ReadLatency - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic                 vld;
    logic                 first;
    logic                 last;
    logic [AddrWidth-1:0] c_addr;
  } beat_t;

  state_t                   state;
  logic [SizeAddrWidth-1:0] m_lim, n_lim, k_lim;
  logic [SizeAddrWidth-1:0] m_cnt, n_cnt, k_cnt;
  logic [AddrWidth-1:0]     k_step;
  logic [AddrWidth-1:0]     a_base, b_base, c_cnt;
  logic [2:0]               drain_cnt;
  beat_t                    pipe [ReadLatency];
  beat_t                    beat_in;
  logic                     issue, k_last, n_last, m_last;

  always_comb begin
    issue   = (state == RUN) && !stall_i;
    k_last  = (k_cnt == k_lim - SizeOne);
    n_last  = (n_cnt == n_lim - SizeOne);
    m_last  = (m_cnt == m_lim - SizeOne);
    beat_in = '0;
    if (issue) begin
      beat_in.vld    = 1'b1;
      beat_in.first  = (k_cnt == '0);
      beat_in.last   = k_last;
      beat_in.c_addr = c_cnt;
    end
  end

  // Strobe delay line; non-issue cycles shift in bubbles so alignment with rdata holds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ReadLatency; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= beat_in;
      for (int i = 1; i < ReadLatency; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign data_valid_o = pipe[ReadLatency-1].vld;
  assign first_k_o    = pipe[ReadLatency-1].first;
  assign last_k_o     = pipe[ReadLatency-1].last;
  assign c_addr_o     = pipe[ReadLatency-1].c_addr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      m_lim         <= '0;
      n_lim         <= '0;
      k_lim         <= '0;
      m_cnt         <= '0;
      n_cnt         <= '0;
      k_cnt         <= '0;
      k_step        <= '0;
      a_base        <= '0;
      b_base        <= '0;
      c_cnt         <= '0;
      drain_cnt     <= '0;
      sram_a_addr_o <= '0;
      sram_b_addr_o <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            m_lim         <= M_size_i;
            n_lim         <= N_size_i;
            k_lim         <= K_size_i;
            k_step        <= AddrWidth'(K_size_i);
            m_cnt         <= '0;
            n_cnt         <= '0;
            k_cnt         <= '0;
            a_base        <= '0;
            b_base        <= '0;
            c_cnt         <= '0;
            sram_a_addr_o <= '0;
            sram_b_addr_o <= '0;
            busy_o        <= 1'b1;
            if ((M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0)) state <= DONE;
            else                                                           state <= RUN;
          end
        end
        RUN: begin
          if (!stall_i) begin
            if (k_last && n_last && m_last) begin
              // Addresses stay parked on the final beat.
              drain_cnt <= '0;
              state     <= DRAIN;
            end else if (!k_last) begin
              k_cnt         <= k_cnt + SizeOne;
              sram_a_addr_o <= sram_a_addr_o + AddrOne;
              sram_b_addr_o <= sram_b_addr_o + AddrOne;
            end else begin
              k_cnt <= '0;
              c_cnt <= c_cnt + AddrOne;
              if (!n_last) begin
                n_cnt         <= n_cnt + SizeOne;
                b_base        <= b_base + k_step;
                sram_b_addr_o <= b_base + k_step;
                sram_a_addr_o <= a_base;
              end else begin
                n_cnt         <= '0;
                m_cnt         <= m_cnt + SizeOne;
                a_base        <= a_base + k_step;
                sram_a_addr_o <= a_base + k_step;
                b_base        <= '0;
                sram_b_addr_o <= '0;
              end
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DrainLast) state <= DONE;
          else                        drain_cnt <= drain_cnt + 3'd1;
        end
        DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GEMM_SEQ_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_cycles_o <= '0;
    end else if ((state == IDLE) && start_i) begin
      perf_cycles_o <= '0;
    end else if (busy_o && (perf_cycles_o != '1)) begin
      perf_cycles_o <= perf_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed-job bench: a loop-nest model predicts every issued address, strobe and done pulse.
module tb_gemm_tile_sequencer;

  localparam int AW = 12;
  localparam int SW = 8;
  localparam int RL = 1;

  logic          clk_i, rst_i, start_i, stall_i;
  logic [SW-1:0] M_size_i, K_size_i, N_size_i;
  logic [AW-1:0] sram_a_addr_o, sram_b_addr_o, c_addr_o;
  logic          data_valid_o, first_k_o, last_k_o, busy_o, done_o;
`ifdef GEMM_SEQ_PERF_CNT_EN
  logic [31:0]   perf_cycles;
`endif

  gemm_tile_sequencer #(.AddrWidth(AW), .SizeAddrWidth(SW), .ReadLatency(RL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .M_size_i(M_size_i), .K_size_i(K_size_i), .N_size_i(N_size_i),
    .stall_i(stall_i),
    .sram_a_addr_o(sram_a_addr_o), .sram_b_addr_o(sram_b_addr_o),
    .data_valid_o(data_valid_o), .first_k_o(first_k_o), .last_k_o(last_k_o),
    .c_addr_o(c_addr_o), .busy_o(busy_o), .done_o(done_o)
`ifdef GEMM_SEQ_PERF_CNT_EN
    , .perf_cycles_o(perf_cycles)
`endif
  );

  typedef struct {int a; int b; int c; bit first; bit last;} exp_beat_t;
  typedef struct {int due; bit first; bit last; int c;} strobe_t;

  exp_beat_t expq[$];
  strobe_t   pend[$];
  int        obs_a[$], obs_b[$], lastc_q[$];

  int errors = 0, checks = 0;
  int cyc = 0;
  int run_from = 0, done_due = -1, done_seen = -1;
  int issued = 0, total = 0;
  int valid_cnt, first_cnt, last_cnt, done_cnt;
  bit job_active = 0, mon_en = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the loop-nest model.
  always @(negedge clk_i) begin
    if (mon_en) begin
      int cur;
      bit ev, ef, el;
      int ec;
      strobe_t s;
      cur = cyc;
      ev = 0; ef = 0; el = 0; ec = 0;
      if (pend.size() > 0 && pend[0].due == cur) begin
        ev = 1; ef = pend[0].first; el = pend[0].last; ec = pend[0].c;
        void'(pend.pop_front());
      end
      chk("data_valid", int'(data_valid_o), int'(ev));
      if (ev) begin
        chk("first_k", int'(first_k_o), int'(ef));
        chk("last_k", int'(last_k_o), int'(el));
        if (el) chk("c_addr", int'(c_addr_o), ec);
      end
      if (data_valid_o === 1'b1) begin
        valid_cnt++;
        if (first_k_o) first_cnt++;
        if (last_k_o) begin last_cnt++; lastc_q.push_back(int'(c_addr_o)); end
      end
      chk("done", int'(done_o), int'(cur == done_due));
      if (done_o === 1'b1) begin done_cnt++; done_seen = cur; end
      if (job_active && cur >= run_from && issued < total) begin
        chk("sram_a_addr", int'(sram_a_addr_o), expq[issued].a);
        chk("sram_b_addr", int'(sram_b_addr_o), expq[issued].b);
        if (!stall_i) begin
          obs_a.push_back(int'(sram_a_addr_o));
          obs_b.push_back(int'(sram_b_addr_o));
          s.due = cur + RL; s.first = expq[issued].first;
          s.last = expq[issued].last; s.c = expq[issued].c;
          pend.push_back(s);
          issued++;
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_a"}, int'(sram_a_addr_o), 0);
    chk({tag, "_b"}, int'(sram_b_addr_o), 0);
    chk({tag, "_vld"}, int'(data_valid_o), 0);
    chk({tag, "_first"}, int'(first_k_o), 0);
    chk({tag, "_last"}, int'(last_k_o), 0);
    chk({tag, "_c"}, int'(c_addr_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_done"}, int'(done_o), 0);
  endtask

  // Runs one job; stall_mask bit c stalls spec cycle c (cycle 0 = start cycle).
  task automatic run_job(input int m, input int k, input int n, input logic [31:0] stall_mask,
                         input int extra_c, input int reset_beat);
    int nst, c, s0;
    expq.delete(); pend.delete(); obs_a.delete(); obs_b.delete(); lastc_q.delete();
    valid_cnt = 0; first_cnt = 0; last_cnt = 0; done_cnt = 0; issued = 0; done_seen = -1;
    for (int mm = 0; mm < m; mm++)
      for (int nn = 0; nn < n; nn++)
        for (int kk = 0; kk < k; kk++) begin
          exp_beat_t e;
          e.a = (mm * k + kk) % (1 << AW);
          e.b = (nn * k + kk) % (1 << AW);
          e.c = (mm * n + nn) % (1 << AW);
          e.first = (kk == 0);
          e.last = (kk == k - 1);
          expq.push_back(e);
        end
    nst = $countones(stall_mask);
    @(posedge clk_i); #1;
    start_i = 1'b1; M_size_i = SW'(m); K_size_i = SW'(k); N_size_i = SW'(n);
    @(posedge clk_i); #1;
    s0 = cyc;
    total = m * n * k;
    run_from = s0;
    done_due = (total == 0) ? s0 + 1 : s0 + total + RL + 1 + nst;
    job_active = 1;
    start_i = 1'b0; M_size_i = 8'd5; K_size_i = 8'd5; N_size_i = 8'd5;
    c = 1;
    stall_i = stall_mask[1];
    chk("busy_after_start", int'(busy_o), 1);
    while (cyc <= done_due + 2) begin
      @(posedge clk_i); #1;
      c++;
      stall_i = (c < 32) ? stall_mask[c[4:0]] : 1'b0;
      start_i = (c == extra_c);
      if (c == extra_c) begin M_size_i = 8'd1; K_size_i = 8'd1; N_size_i = 8'd1; end
      if (reset_beat > 0 && issued >= reset_beat) begin
        #1;
        rst_i = 1'b1;
        job_active = 0; pend.delete(); done_due = -1;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        break;
      end
    end
    stall_i = 1'b0; start_i = 1'b0; job_active = 0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("busy_after_job", int'(busy_o), 0);
    chk("beats_issued_by_model", issued, (reset_beat > 0) ? issued : total);
`ifdef GEMM_SEQ_PERF_CNT_EN
    if (reset_beat == 0) chk("perf_cycles", int'(perf_cycles), done_due - s0);
`endif
    s0 = done_seen - s0;
    done_seen = s0;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0;
    M_size_i = '0; K_size_i = '0; N_size_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    rst_i = 1'b0;
    mon_en = 1;

    // M=1 K=16 N=4
    run_job(1, 16, 4, 32'h0, -1, 0);
    chk("j1_valid_cnt", valid_cnt, 64);
    chk("j1_last_cnt", last_cnt, 4);
    for (int i = 0; i < 4; i++) chk("j1_last_c", (i < lastc_q.size()) ? lastc_q[i] : -1, i);
    chk("j1_a17", (obs_a.size() > 17) ? obs_a[17] : -1, 1);
    chk("j1_b17", (obs_b.size() > 17) ? obs_b[17] : -1, 17);
    chk("j1_done_cnt", done_cnt, 1);
    chk("j1_done_latency", done_seen, 66);

    // M=4 K=16 N=1
    run_job(4, 16, 1, 32'h0, -1, 0);
    chk("j2_valid_cnt", valid_cnt, 64);
    chk("j2_first_cnt", first_cnt, 4);
    for (int i = 0; i < 4; i++) chk("j2_last_c", (i < lastc_q.size()) ? lastc_q[i] : -1, i);
    chk("j2_a17", (obs_a.size() > 17) ? obs_a[17] : -1, 17);
    chk("j2_b17", (obs_b.size() > 17) ? obs_b[17] : -1, 1);

    // M=K=N=8
    run_job(8, 8, 8, 32'h0, -1, 0);
    chk("j3_valid_cnt", valid_cnt, 512);
    chk("j3_a9", (obs_a.size() > 9) ? obs_a[9] : -1, 1);
    chk("j3_b9", (obs_b.size() > 9) ? obs_b[9] : -1, 9);
    chk("j3_a511", (obs_a.size() > 511) ? obs_a[511] : -1, 63);
    chk("j3_b511", (obs_b.size() > 511) ? obs_b[511] : -1, 63);
    chk("j3_last_c", (lastc_q.size() > 0) ? lastc_q[lastc_q.size()-1] : -1, 63);

    // M=2 K=3 N=2, stalls on cycles 2, 3 and 7
    run_job(2, 3, 2, 32'h0000_008C, -1, 0);
    chk("j4_valid_cnt", valid_cnt, 12);
    chk("j4_done_latency", done_seen, 17);
    chk("j4_done_cnt", done_cnt, 1);

    // K=0 with M=N=4
    run_job(4, 0, 4, 32'h0, -1, 0);
    chk("j5_valid_cnt", valid_cnt, 0);
    chk("j5_done_latency", done_seen, 1);

    // M=K=N=2 with a second start on cycle 3
    run_job(2, 2, 2, 32'h0, 3, 0);
    chk("j6_valid_cnt", valid_cnt, 8);
    chk("j6_done_cnt", done_cnt, 1);

    // M=K=N=4 reset after 5 beats
    run_job(4, 4, 4, 32'h0, -1, 5);
    chk("j7_done_cnt", done_cnt, 0);

    // M=K=N=1 after the reset
    run_job(1, 1, 1, 32'h0, -1, 0);
    chk("j8_valid_cnt", valid_cnt, 1);
    chk("j8_first_cnt", first_cnt, 1);
    chk("j8_last_cnt", last_cnt, 1);
    chk("j8_last_c", (lastc_q.size() > 0) ? lastc_q[0] : -1, 0);
    chk("j8_done_cnt", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
